// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, runs the ALU, issues the data-SRAM
// request for loads/stores and feeds the memory stage and decode forwarding.

module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic        op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
  logic        op_or, op_xor, op_sll, op_srl, op_sra, op_lui;
  logic [31:0] adder_b;
  logic        adder_cin;
  logic [32:0] adder_sum;
  logic        slt_bit, sltu_bit;
  logic [31:0] sll_res, srl_res, sra_res;

  assign op_add  = alu_op[0];
  assign op_sub  = alu_op[1];
  assign op_slt  = alu_op[2];
  assign op_sltu = alu_op[3];
  assign op_and  = alu_op[4];
  assign op_nor  = alu_op[5];
  assign op_or   = alu_op[6];
  assign op_xor  = alu_op[7];
  assign op_sll  = alu_op[8];
  assign op_srl  = alu_op[9];
  assign op_sra  = alu_op[10];
  assign op_lui  = alu_op[11];

  // Shared adder: subtract and both compares run src1 + ~src2 + 1
  always_comb begin
    adder_cin = op_sub | op_slt | op_sltu;
    adder_b   = adder_cin ? ~alu_src2 : alu_src2;
    adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, adder_cin};
    slt_bit   = (alu_src1[31] & ~alu_src2[31])
              | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
    sltu_bit  = ~adder_sum[32];
    sll_res   = alu_src1 << alu_src2[4:0];
    srl_res   = alu_src1 >> alu_src2[4:0];
    sra_res   = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
  end

  // One-hot result select; no op selected yields zero
  always_comb begin
    alu_result = ({32{op_add | op_sub}} & adder_sum[31:0])
               | ({32{op_slt}}          & {31'd0, slt_bit})
               | ({32{op_sltu}}         & {31'd0, sltu_bit})
               | ({32{op_and}}          & (alu_src1 & alu_src2))
               | ({32{op_nor}}          & ~(alu_src1 | alu_src2))
               | ({32{op_or}}           & (alu_src1 | alu_src2))
               | ({32{op_xor}}          & (alu_src1 ^ alu_src2))
               | ({32{op_sll}}          & sll_res)
               | ({32{op_srl}}          & srl_res)
               | ({32{op_sra}}          & sra_res)
               | ({32{op_lui}}          & alu_src2);
  end

endmodule

module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 150,
  parameter int ES_TO_MS_BUS_WD = 71
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [37:0]                es_to_ds_bus,
  output logic                       data_sram_req,
  output logic                       data_sram_wr,
  output logic [3:0]                 data_sram_wstrb,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  input  logic                       data_sram_addr_ok
);

  logic                       es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus_r;
  logic                       req_done;
  logic                       es_ready_go;

  logic [11:0] es_alu_op;
  logic        es_res_from_mem, es_src1_is_pc, es_src2_is_imm;
  logic        es_gr_we, es_mem_we, es_mem_op;
  logic [4:0]  es_dest;
  logic [31:0] es_imm, es_rj_value, es_rkd_value, es_pc;
  logic [31:0] alu_src1, alu_src2, alu_result;

  assign es_alu_op       = ds_to_es_bus_r[149:138];
  assign es_res_from_mem = ds_to_es_bus_r[137];
  assign es_src1_is_pc   = ds_to_es_bus_r[136];
  assign es_src2_is_imm  = ds_to_es_bus_r[135];
  assign es_gr_we        = ds_to_es_bus_r[134];
  assign es_mem_we       = ds_to_es_bus_r[133];
  assign es_dest         = ds_to_es_bus_r[132:128];
  assign es_imm          = ds_to_es_bus_r[127:96];
  assign es_rj_value     = ds_to_es_bus_r[95:64];
  assign es_rkd_value    = ds_to_es_bus_r[63:32];
  assign es_pc           = ds_to_es_bus_r[31:0];

  // Operand selection feeding the ALU
  always_comb begin
    alu_src1 = es_src1_is_pc  ? es_pc  : es_rj_value;
    alu_src2 = es_src2_is_imm ? es_imm : es_rkd_value;
  end

  alu u_alu (
    .alu_op     (es_alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result)
  );

  // Handshake, memory request and outgoing buses
  always_comb begin
    es_mem_op       = es_res_from_mem | es_mem_we;
    // Gating on ms_allowin keeps the request from being accepted while
    // memory cannot take the instruction, so no response can be dropped.
    data_sram_req   = es_valid & es_mem_op & ~req_done & ms_allowin;
    data_sram_wr    = es_mem_we;
    data_sram_wstrb = es_mem_we ? 4'hf : 4'h0;
    data_sram_addr  = alu_result;
    data_sram_wdata = es_rkd_value;
    es_ready_go     = ~es_mem_op | req_done | (data_sram_req & data_sram_addr_ok);
    es_allowin      = ~es_valid | (es_ready_go & ms_allowin);
    es_to_ms_valid  = es_valid & es_ready_go;
    es_to_ms_bus    = {es_res_from_mem, es_gr_we, es_dest, alu_result, es_pc};
    es_to_ds_bus    = {es_valid & es_res_from_mem,
                       (es_valid & es_gr_we) ? es_dest : 5'd0,
                       alu_result};
  end

  // Stage occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  // Instruction register: holds while stalled so request inputs stay stable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_to_es_bus_r <= '0;
    end else if (ds_to_es_valid && es_allowin) begin
      ds_to_es_bus_r <= ds_to_es_bus;
    end
  end

  // Remembers an accepted request until the instruction leaves
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_done <= 1'b0;
    end else if (es_to_ms_valid && ms_allowin) begin
      req_done <= 1'b0;
    end else if (data_sram_req && data_sram_addr_ok && !ms_allowin) begin
      req_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with a reference model of stage occupancy.

module tb_exe_stage;

  typedef struct {
    logic [11:0] op;
    logic        rfm;
    logic        s1pc;
    logic        s2imm;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [31:0] pc;
  } insn_t;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [149:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [37:0]  es_to_ds_bus;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;

  int checks = 0;
  int failures = 0;

  insn_t cur_in;
  insn_t occ;
  logic  mv;

  exe_stage #(.DS_TO_ES_BUS_WD(150), .ES_TO_MS_BUS_WD(71)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_allowin        (ms_allowin),
    .es_allowin        (es_allowin),
    .ds_to_es_valid    (ds_to_es_valid),
    .ds_to_es_bus      (ds_to_es_bus),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_to_ds_bus      (es_to_ds_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [149:0] pack(insn_t i);
    return {i.op, i.rfm, i.s1pc, i.s2imm, i.gr_we, i.mem_we, i.dest,
            i.imm, i.rj, i.rkd, i.pc};
  endfunction

  function automatic insn_t mk(logic [11:0] op, logic rfm, logic s1pc, logic s2imm,
                               logic gr_we, logic mem_we, logic [4:0] dest,
                               logic [31:0] imm, logic [31:0] rj,
                               logic [31:0] rkd, logic [31:0] pc);
    insn_t i;
    i.op = op; i.rfm = rfm; i.s1pc = s1pc; i.s2imm = s2imm; i.gr_we = gr_we;
    i.mem_we = mem_we; i.dest = dest; i.imm = imm; i.rj = rj; i.rkd = rkd; i.pc = pc;
    return i;
  endfunction

  // Architectural result of the instruction
  function automatic logic [31:0] ref_alu(insn_t i);
    logic [31:0] a, b;
    a = i.s1pc  ? i.pc  : i.rj;
    b = i.s2imm ? i.imm : i.rkd;
    case (i.op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      OP_LUI:  return b;
      default: return 32'd0;
    endcase
  endfunction

  // A memory instruction finishes in the cycle its request is accepted;
  // anything else finishes immediately.
  function automatic logic m_req();
    return mv && (occ.rfm || occ.mem_we) && ms_allowin;
  endfunction
  function automatic logic m_done();
    return !(occ.rfm || occ.mem_we) || (m_req() && data_sram_addr_ok);
  endfunction
  function automatic logic m_allowin();
    return !mv || (m_done() && ms_allowin);
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of which instruction occupies the stage
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mv  = 1'b0;
      occ = mk(12'd0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    end else if (m_allowin()) begin
      if (ds_to_es_valid) occ = cur_in;
      mv = ds_to_es_valid;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      chk("m_allowin",  es_allowin,      m_allowin());
      chk("m_ms_valid", es_to_ms_valid,  mv && m_done());
      chk("m_ms_bus",   es_to_ms_bus,    {occ.rfm, occ.gr_we, occ.dest, ref_alu(occ), occ.pc});
      chk("m_ds_bus",   es_to_ds_bus,    {mv & occ.rfm, (mv & occ.gr_we) ? occ.dest : 5'd0, ref_alu(occ)});
      chk("m_req",      data_sram_req,   m_req());
      chk("m_wr",       data_sram_wr,    occ.mem_we);
      chk("m_wstrb",    data_sram_wstrb, occ.mem_we ? 4'hf : 4'h0);
      chk("m_addr",     data_sram_addr,  ref_alu(occ));
      chk("m_wdata",    data_sram_wdata, occ.rkd);
    end else if (resetn === 1'b0) begin
      chk("rst_allowin",  es_allowin,     1'b1);
      chk("rst_ms_valid", es_to_ms_valid, 1'b0);
      chk("rst_req",      data_sram_req,  1'b0);
      chk("rst_ds_bus",   es_to_ds_bus,   38'd0);
    end
  end

  task automatic drive(insn_t i, logic v);
    cur_in = i;
    ds_to_es_bus = pack(i);
    ds_to_es_valid = v;
  endtask

  task automatic to_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  insn_t nop, i_add, i_st, i_ld, i_bl, i_sra, i_st2;
  int req_cycles;

  initial begin
    nop   = mk(12'd0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    i_add = mk(OP_ADD, 0, 0, 0, 1, 0, 5'd3, 32'd0, 32'd5, 32'd7, 32'h1c00_0010);
    i_st  = mk(OP_ADD, 0, 0, 1, 0, 1, 5'd0, 32'd8, 32'h1000, 32'hdeadbeef, 32'h1c00_0014);
    i_ld  = mk(OP_ADD, 1, 0, 1, 1, 0, 5'd4, 32'd4, 32'h2000, 32'd0, 32'h1c00_0018);
    i_bl  = mk(OP_ADD, 0, 1, 1, 1, 0, 5'd1, 32'd4, 32'd0, 32'd0, 32'h1c00_0000);
    i_sra = mk(OP_SRA, 0, 0, 1, 1, 0, 5'd6, 32'd4, 32'h8000_0000, 32'd0, 32'h1c00_0004);
    i_st2 = mk(OP_ADD, 0, 0, 1, 0, 1, 5'd0, 32'd0, 32'h3000, 32'h1234_5678, 32'h1c00_0020);

    resetn = 1'b0;
    ms_allowin = 1'b1;
    data_sram_addr_ok = 1'b0;
    drive(nop, 1'b0);
    to_neg();
    chk("reset_allowin", es_allowin, 1'b1);
    chk("reset_ds_bus", es_to_ds_bus, 38'd0);
    to_pos();
    resetn = 1'b1;
    to_pos();

    // add.w r3 = 5 + 7
    drive(i_add, 1'b1);
    to_pos();
    drive(nop, 1'b0);
    to_neg();
    chk("add_valid", es_to_ms_valid, 1'b1);
    chk("add_result", es_to_ms_bus[63:32], 32'd12);
    chk("add_ds_bus", es_to_ds_bus, {1'b0, 5'd3, 32'd12});
    to_pos();

    // st.w with addr_ok low for three cycles
    drive(i_st, 1'b1);
    to_pos();
    drive(nop, 1'b0);
    req_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      if (data_sram_req) req_cycles++;
      chk("st_wait_allowin", es_allowin, 1'b0);
      chk("st_wait_valid", es_to_ms_valid, 1'b0);
      chk("st_wait_addr", data_sram_addr, 32'h1008);
      to_pos();
    end
    data_sram_addr_ok = 1'b1;
    to_neg();
    if (data_sram_req) req_cycles++;
    chk("st_req_fields", {data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata},
        {1'b1, 4'hf, 32'h1008, 32'hdeadbeef});
    chk("st_leave_valid", es_to_ms_valid, 1'b1);
    chk("st_leave_allowin", es_allowin, 1'b1);
    to_pos();
    data_sram_addr_ok = 1'b0;
    to_neg();
    if (data_sram_req) req_cycles++;
    chk("st_gone_valid", es_to_ms_valid, 1'b0);
    chk("st_req_cycles", req_cycles, 4);
    to_pos();

    // ld.w r4 with addr_ok already high
    drive(i_ld, 1'b1);
    data_sram_addr_ok = 1'b1;
    to_pos();
    drive(nop, 1'b0);
    to_neg();
    chk("ld_ds_bus", es_to_ds_bus, {1'b1, 5'd4, 32'h2004});
    chk("ld_req", data_sram_req, 1'b1);
    chk("ld_ms_rfm", es_to_ms_bus[70], 1'b1);
    chk("ld_ms_valid", es_to_ms_valid, 1'b1);
    to_pos();
    to_neg();
    chk("ld_one_req", data_sram_req, 1'b0);
    to_pos();

    // ld.w resident while memory is stalled
    ms_allowin = 1'b0;
    drive(i_ld, 1'b1);
    to_pos();
    drive(nop, 1'b0);
    for (int c = 0; c < 2; c++) begin
      to_neg();
      chk("stall_req", data_sram_req, 1'b0);
      chk("stall_allowin", es_allowin, 1'b0);
      chk("stall_bus", es_to_ms_bus, {1'b1, 1'b1, 5'd4, 32'h2004, 32'h1c00_0018});
      to_pos();
    end
    ms_allowin = 1'b1;
    to_neg();
    chk("unstall_req", data_sram_req, 1'b1);
    chk("unstall_valid", es_to_ms_valid, 1'b1);
    to_pos();

    // bl then srai.w back to back
    drive(i_bl, 1'b1);
    to_pos();
    drive(i_sra, 1'b1);
    to_neg();
    chk("bl_result", es_to_ds_bus, {1'b0, 5'd1, 32'h1c00_0004});
    to_pos();
    drive(nop, 1'b0);
    to_neg();
    chk("srai_result", es_to_ms_bus[63:32], 32'hf800_0000);
    to_pos();

    // Remaining ALU ops, back to back, checked by the model
    drive(mk(OP_SUB,  0, 0, 0, 1, 0, 5'd7, 32'd0, 32'd5, 32'd7, 32'h40), 1'b1);
    to_pos();
    drive(mk(OP_SLT,  0, 0, 0, 1, 0, 5'd7, 32'd0, 32'hffff_fffe, 32'd1, 32'h44), 1'b1);
    to_pos();
    drive(mk(OP_SLTU, 0, 0, 0, 1, 0, 5'd7, 32'd0, 32'hffff_fffe, 32'd1, 32'h48), 1'b1);
    to_pos();
    drive(mk(OP_AND,  0, 0, 0, 1, 0, 5'd7, 32'd0, 32'hf0f0_1234, 32'h0ff0_ff00, 32'h4c), 1'b1);
    to_pos();
    drive(mk(OP_NOR,  0, 0, 0, 1, 0, 5'd7, 32'd0, 32'hf0f0_1234, 32'h0ff0_ff00, 32'h50), 1'b1);
    to_pos();
    drive(mk(OP_OR,   0, 0, 0, 1, 0, 5'd7, 32'd0, 32'hf0f0_1234, 32'h0ff0_ff00, 32'h54), 1'b1);
    to_pos();
    drive(mk(OP_XOR,  0, 0, 0, 1, 0, 5'd7, 32'd0, 32'hf0f0_1234, 32'h0ff0_ff00, 32'h58), 1'b1);
    to_pos();
    drive(mk(OP_SLL,  0, 0, 0, 1, 0, 5'd7, 32'd0, 32'h8000_0003, 32'h0000_0024, 32'h5c), 1'b1);
    to_pos();
    drive(mk(OP_SRL,  0, 0, 0, 1, 0, 5'd7, 32'd0, 32'h8000_0003, 32'h0000_0021, 32'h60), 1'b1);
    to_pos();
    drive(mk(OP_LUI,  0, 0, 1, 1, 0, 5'd7, 32'habcd_e000, 32'd0, 32'd0, 32'h64), 1'b1);
    to_pos();
    drive(nop, 1'b0);
    to_pos();

    // Back-to-back stores with addr_ok high every cycle
    data_sram_addr_ok = 1'b1;
    drive(i_st, 1'b1);
    to_pos();
    drive(i_st2, 1'b1);
    to_neg();
    chk("b2b_req1", data_sram_req, 1'b1);
    chk("b2b_allowin1", es_allowin, 1'b1);
    to_pos();
    drive(nop, 1'b0);
    to_neg();
    chk("b2b_req2", {data_sram_req, data_sram_addr}, {1'b1, 32'h3000});
    to_pos();

    // Empty stage, bus carries a store but valid is low
    drive(i_st, 1'b0);
    to_pos();
    to_neg();
    chk("empty_req", data_sram_req, 1'b0);
    chk("empty_valid", es_to_ms_valid, 1'b0);
    to_pos();
    drive(nop, 1'b0);

    // Asynchronous reset while a request is outstanding
    data_sram_addr_ok = 1'b0;
    drive(i_st, 1'b1);
    to_pos();
    drive(nop, 1'b0);
    to_neg();
    chk("pre_rst_req", data_sram_req, 1'b1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_req", data_sram_req, 1'b0);
    chk("async_valid", es_to_ms_valid, 1'b0);
    chk("async_ds_bus", es_to_ds_bus, 38'd0);
    to_pos();
    resetn = 1'b1;
    to_neg();
    chk("post_rst_allowin", es_allowin, 1'b1);
    to_pos();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
